// File: rtl/seq_game_pkg.sv
// Shared types and constants for the sequence-memory game core.
// The LFSR tap mask selects bits 16,14,13,11 (1-based) of the 16-bit register.
package seq_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_ENTER,
        S_DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int cnt_w(input int p);
        return $clog2(p) + 1;
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// 16-bit Fibonacci LFSR; next_o is the value the register takes on the next step.
// Exposing the post-step value lets the core store a digit in the same cycle it steps.
module seq_lfsr
    import seq_game_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    output logic [OUT_W-1:0] next_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    assign next_o = lfsr_d[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/seq_game_core.sv
// Sequence-memory game engine: generates, shows and verifies a digit sequence.
// All outputs are registered from the next-state values, so pulses lag their cause by one cycle.
module seq_game_core
    import seq_game_pkg::*;
#(
    parameter int          DIGIT_W       = 4,
    parameter int          MAX_LEVEL     = 8,
    parameter int          DISP_CYCLES   = 50_000_000,
    parameter int          GAP_CYCLES    = 12_500_000,
    parameter int          ENTRY_TIMEOUT = 250_000_000,
    parameter int          LIVES         = 3,
    parameter int          APPEND_MODE   = 0,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               submit,
    input  logic [DIGIT_W-1:0] entry,
    output logic [DIGIT_W-1:0] show_digit,
    output logic               show_valid,
    output logic [3:0]         level,
    output logic [2:0]         lives_left,
    output logic               accepting,
    output logic               correct,
    output logic               incorrect,
    output logic               round_done,
    output logic               game_over,
    output logic               game_win
);

    localparam int SHOW_MAX = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
    localparam int SHOW_W   = cnt_w(SHOW_MAX);
    localparam int TMO_W    = cnt_w(ENTRY_TIMEOUT);
    localparam int IDX_W    = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    localparam logic [SHOW_W-1:0] DISP_LD  = SHOW_W'(DISP_CYCLES - 1);
    localparam logic [SHOW_W-1:0] GAP_LD   = SHOW_W'(GAP_CYCLES - 1);
    localparam logic [SHOW_W-1:0] SHOW_ONE = SHOW_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LD   = TMO_W'(ENTRY_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [3:0]        LVL_MAX  = 4'(MAX_LEVEL);
    localparam logic [2:0]        LIVES_LD = 3'(LIVES);

    state_e              state_q, state_d;
    logic [3:0]          level_q, level_d;
    logic [2:0]          lives_q, lives_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SHOW_W-1:0]   show_cnt_q, show_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DIGIT_W-1:0]  seq_q [MAX_LEVEL];
    logic [DIGIT_W-1:0]  seq_d [MAX_LEVEL];

    logic [DIGIT_W-1:0]  show_digit_q, show_digit_d;
    logic                show_valid_q, show_valid_d;
    logic                accepting_q, accepting_d;
    logic                correct_q, correct_d;
    logic                incorrect_q, incorrect_d;
    logic                round_done_q, round_done_d;
    logic                game_over_q, game_over_d;
    logic                game_win_q, game_win_d;

    logic                lfsr_step;
    logic [DIGIT_W-1:0]  lfsr_digit;
    logic [IDX_W-1:0]    last_pos;
    logic                last_idx;
    logic                miss;

    seq_lfsr #(
        .SEED  (SEED),
        .OUT_W (DIGIT_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step_i (lfsr_step),
        .next_o (lfsr_digit)
    );

    assign last_pos = IDX_W'(level_q - 4'd1);
    assign last_idx = (idx_q == last_pos);

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        idx_d        = idx_q;
        show_cnt_d   = show_cnt_q;
        tmo_d        = tmo_q;
        seq_d        = seq_q;
        correct_d    = 1'b0;
        incorrect_d  = 1'b0;
        round_done_d = 1'b0;
        game_over_d  = 1'b0;
        game_win_d   = 1'b0;
        lfsr_step    = 1'b0;
        miss         = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_GEN;
                    level_d = 4'd1;
                    lives_d = LIVES_LD;
                    idx_d   = '0;
                end
            end
            S_GEN: begin
                lfsr_step = 1'b1;
                if (APPEND_MODE != 0) begin
                    seq_d[last_pos] = lfsr_digit;
                    state_d         = S_SHOW_ON;
                    idx_d           = '0;
                    show_cnt_d      = DISP_LD;
                end else begin
                    seq_d[idx_q] = lfsr_digit;
                    if (last_idx) begin
                        state_d    = S_SHOW_ON;
                        idx_d      = '0;
                        show_cnt_d = DISP_LD;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            S_SHOW_ON: begin
                if (show_cnt_q == '0) begin
                    state_d    = S_SHOW_GAP;
                    show_cnt_d = GAP_LD;
                end else begin
                    show_cnt_d = show_cnt_q - SHOW_ONE;
                end
            end
            S_SHOW_GAP: begin
                if (show_cnt_q != '0) begin
                    show_cnt_d = show_cnt_q - SHOW_ONE;
                end else if (last_idx) begin
                    state_d = S_ENTER;
                    idx_d   = '0;
                    tmo_d   = TMO_LD;
                end else begin
                    state_d    = S_SHOW_ON;
                    idx_d      = idx_q + IDX_ONE;
                    show_cnt_d = DISP_LD;
                end
            end
            S_ENTER: begin
                tmo_d = tmo_q - TMO_ONE;
                // A submit on the expiry cycle is judged on its value alone.
                if (submit) begin
                    tmo_d = TMO_LD;
                    if (entry == seq_q[idx_q]) begin
                        correct_d = 1'b1;
                        if (last_idx) begin
                            round_done_d = 1'b1;
                            idx_d        = '0;
                            if (level_q == LVL_MAX) begin
                                game_win_d = 1'b1;
                                state_d    = S_DONE;
                            end else begin
                                level_d = level_q + 4'd1;
                                state_d = S_GEN;
                            end
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        miss = 1'b1;
                    end
                end else if (tmo_q == TMO_ONE) begin
                    miss = 1'b1;
                end
                if (miss) begin
                    incorrect_d = 1'b1;
                    lives_d     = lives_q - 3'd1;
                    idx_d       = '0;
                    if (lives_q == 3'd1) begin
                        game_over_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d    = S_SHOW_ON;
                        show_cnt_d = DISP_LD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accepting_d  = (state_d == S_ENTER);
        show_valid_d = (state_d == S_SHOW_ON);
        show_digit_d = show_valid_d ? seq_d[idx_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            level_q      <= 4'd1;
            lives_q      <= LIVES_LD;
            idx_q        <= '0;
            show_cnt_q   <= '0;
            tmo_q        <= '0;
            seq_q        <= '{default: '0};
            show_digit_q <= '0;
            show_valid_q <= 1'b0;
            accepting_q  <= 1'b0;
            correct_q    <= 1'b0;
            incorrect_q  <= 1'b0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
            game_win_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            idx_q        <= idx_d;
            show_cnt_q   <= show_cnt_d;
            tmo_q        <= tmo_d;
            seq_q        <= seq_d;
            show_digit_q <= show_digit_d;
            show_valid_q <= show_valid_d;
            accepting_q  <= accepting_d;
            correct_q    <= correct_d;
            incorrect_q  <= incorrect_d;
            round_done_q <= round_done_d;
            game_over_q  <= game_over_d;
            game_win_q   <= game_win_d;
        end
    end

    assign show_digit = show_digit_q;
    assign show_valid = show_valid_q;
    assign level      = level_q;
    assign lives_left = lives_q;
    assign accepting  = accepting_q;
    assign correct    = correct_q;
    assign incorrect  = incorrect_q;
    assign round_done = round_done_q;
    assign game_over  = game_over_q;
    assign game_win   = game_win_q;

endmodule

// File: tb/tb_seq_game_core.sv
// Directed bench for seq_game_core: one regenerate-mode and one append-mode instance.
// Digits come from an independent LFSR model plus hand-computed constants (3,7,F,E,C,9).
module tb_seq_game_core;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst, start, submit, sel;
    logic [3:0] entry;

    logic       start_m, start_a, submit_m, submit_a;
    logic [3:0] m_sd, a_sd, m_lvl, a_lvl;
    logic [2:0] m_lives, a_lives;
    logic       m_sv, a_sv, m_acc, a_acc, m_cor, a_cor, m_inc, a_inc;
    logic       m_rd, a_rd, m_go, a_go, m_win, a_win;

    logic [3:0] sd, lvl;
    logic [2:0] lives;
    logic       sv, acc, cor, inc, rd, go, win;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_lfsr;
    logic [3:0]  exp_seq [0:7];

    always #5 clk = ~clk;

    assign start_m  = start & ~sel;
    assign start_a  = start & sel;
    assign submit_m = submit & ~sel;
    assign submit_a = submit & sel;

    assign sd    = sel ? a_sd : m_sd;
    assign sv    = sel ? a_sv : m_sv;
    assign lvl   = sel ? a_lvl : m_lvl;
    assign lives = sel ? a_lives : m_lives;
    assign acc   = sel ? a_acc : m_acc;
    assign cor   = sel ? a_cor : m_cor;
    assign inc   = sel ? a_inc : m_inc;
    assign rd    = sel ? a_rd : m_rd;
    assign go    = sel ? a_go : m_go;
    assign win   = sel ? a_win : m_win;

    seq_game_core #(
        .DIGIT_W(4), .MAX_LEVEL(3), .DISP_CYCLES(3), .GAP_CYCLES(1),
        .ENTRY_TIMEOUT(10), .LIVES(2), .APPEND_MODE(0), .SEED(SEED)
    ) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .submit(submit_m),
        .entry(entry), .show_digit(m_sd), .show_valid(m_sv),
        .level(m_lvl), .lives_left(m_lives), .accepting(m_acc),
        .correct(m_cor), .incorrect(m_inc), .round_done(m_rd),
        .game_over(m_go), .game_win(m_win)
    );

    seq_game_core #(
        .DIGIT_W(4), .MAX_LEVEL(3), .DISP_CYCLES(3), .GAP_CYCLES(1),
        .ENTRY_TIMEOUT(10), .LIVES(2), .APPEND_MODE(1), .SEED(SEED)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .submit(submit_a),
        .entry(entry), .show_digit(a_sd), .show_valid(a_sv),
        .level(a_lvl), .lives_left(a_lives), .accepting(a_acc),
        .correct(a_cor), .incorrect(a_inc), .round_done(a_rd),
        .game_over(a_go), .game_win(a_win)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_gen(input int lv, input bit app);
        if (app) begin
            ref_lfsr = lfsr_next(ref_lfsr);
            exp_seq[lv-1] = ref_lfsr[3:0];
        end else begin
            for (int i = 0; i < lv; i++) begin
                ref_lfsr = lfsr_next(ref_lfsr);
                exp_seq[i] = ref_lfsr[3:0];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; submit = 1'b0; entry = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        ref_lfsr = SEED;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        entry = d;
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    task automatic check_show(input int n);
        int w, run, gap;
        logic bad;
        logic [3:0] seen;
        w = 0;
        while (sv !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (sv !== 1'b1) begin
            errors++;
            $display("FAIL show_start: show_valid=%b required 1", sv);
        end
        for (int i = 0; i < n; i++) begin
            run = 0; bad = 1'b0; seen = sd;
            while (sv === 1'b1 && run < 10) begin
                if (sd !== exp_seq[i]) begin
                    bad = 1'b1;
                    seen = sd;
                end
                run++;
                tick();
            end
            checks++;
            if (run != 3 || bad) begin
                errors++;
                $display("FAIL show_digit[%0d]: len=%0d digit=%h required len=3 digit=%h",
                         i, run, seen, exp_seq[i]);
            end
            gap = 0;
            while (sv !== 1'b1 && acc !== 1'b1 && gap < 10) begin
                gap++;
                tick();
            end
            checks++;
            if (gap != 1 || acc !== ((i == n - 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL show_gap[%0d]: gap=%0d accepting=%b required gap=1 accepting=%b",
                         i, gap, acc, (i == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        checks++;
        if (sv !== 1'b0 || sd !== 4'h0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL reset_show: sv=%b sd=%h acc=%b required 0 0 0", sv, sd, acc);
        end
        checks++;
        if (lvl !== 4'd1 || lives !== 3'd2) begin
            errors++;
            $display("FAIL reset_regs: level=%0d lives=%0d required 1 2", lvl, lives);
        end
        checks++;
        if ({cor, inc, rd, go, win} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: %b required 00000", {cor, inc, rd, go, win});
        end
        press(4'h3);
        checks++;
        if (cor !== 1'b0 || inc !== 1'b0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL idle_submit: cor=%b inc=%b acc=%b required 0 0 0", cor, inc, acc);
        end
    endtask

    task automatic test_level1();
        model_gen(1, 1'b0);
        pulse_start();
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL gen_blank: show_valid=%b required 0", sv);
        end
        tick();
        checks++;
        if (sv !== 1'b1 || sd !== 4'h3) begin
            errors++;
            $display("FAIL first_digit: sv=%b sd=%h required 1 3", sv, sd);
        end
        tick();
        tick();
        checks++;
        if (sv !== 1'b1 || sd !== 4'h3) begin
            errors++;
            $display("FAIL third_show_cycle: sv=%b sd=%h required 1 3", sv, sd);
        end
        tick();
        checks++;
        if (sv !== 1'b0 || sd !== 4'h0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL gap_cycle: sv=%b sd=%h acc=%b required 0 0 0", sv, sd, acc);
        end
        tick();
        checks++;
        if (acc !== 1'b1 || lvl !== 4'd1 || lives !== 3'd2) begin
            errors++;
            $display("FAIL enter_l1: acc=%b level=%0d lives=%0d required 1 1 2", acc, lvl, lives);
        end
    endtask

    task automatic test_win();
        press(4'h3);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1 || lvl !== 4'd2 || win !== 1'b0) begin
            errors++;
            $display("FAIL win_l1: cor=%b rd=%b level=%0d win=%b required 1 1 2 0", cor, rd, lvl, win);
        end
        model_gen(2, 1'b0);
        check_show(2);
        press(4'h7);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b0 || acc !== 1'b1) begin
            errors++;
            $display("FAIL win_l2a: cor=%b rd=%b acc=%b required 1 0 1", cor, rd, acc);
        end
        press(4'hF);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1 || lvl !== 4'd3) begin
            errors++;
            $display("FAIL win_l2b: cor=%b rd=%b level=%0d required 1 1 3", cor, rd, lvl);
        end
        model_gen(3, 1'b0);
        check_show(3);
        press(4'hE);
        press(4'hC);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b0 || win !== 1'b0) begin
            errors++;
            $display("FAIL win_l3b: cor=%b rd=%b win=%b required 1 0 0", cor, rd, win);
        end
        press(4'h9);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1 || win !== 1'b1 || acc !== 1'b0) begin
            errors++;
            $display("FAIL win_final: cor=%b rd=%b win=%b acc=%b required 1 1 1 0", cor, rd, win, acc);
        end
        tick();
        checks++;
        if (win !== 1'b0 || cor !== 1'b0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL win_width: win=%b cor=%b acc=%b required 0 0 0", win, cor, acc);
        end
    endtask

    task automatic test_mismatch();
        sel = 1'b0;
        do_reset();
        pulse_start();
        model_gen(1, 1'b0);
        check_show(1);
        press(4'h3);
        model_gen(2, 1'b0);
        check_show(2);
        press(4'h0);
        checks++;
        if (inc !== 1'b1 || cor !== 1'b0 || lives !== 3'd1 || go !== 1'b0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL mismatch: inc=%b cor=%b lives=%0d go=%b acc=%b required 1 0 1 0 0",
                     inc, cor, lives, go, acc);
        end
        check_show(2);
        checks++;
        if (lvl !== 4'd2) begin
            errors++;
            $display("FAIL replay_level: level=%0d required 2", lvl);
        end
        press(4'h7);
        checks++;
        if (cor !== 1'b1) begin
            errors++;
            $display("FAIL replay_entry: cor=%b required 1", cor);
        end
    endtask

    task automatic test_timeout();
        int n;
        sel = 1'b0;
        do_reset();
        pulse_start();
        model_gen(1, 1'b0);
        check_show(1);
        n = 0;
        while (inc !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10 || lives !== 3'd1 || go !== 1'b0) begin
            errors++;
            $display("FAIL timeout1: cycles=%0d lives=%0d go=%b required 10 1 0", n, lives, go);
        end
        check_show(1);
        n = 0;
        while (inc !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10 || go !== 1'b1 || lives !== 3'd0 || acc !== 1'b0) begin
            errors++;
            $display("FAIL timeout2: cycles=%0d go=%b lives=%0d acc=%b required 10 1 0 0",
                     n, go, lives, acc);
        end
        tick();
        checks++;
        if (go !== 1'b0 || inc !== 1'b0) begin
            errors++;
            $display("FAIL over_width: go=%b inc=%b required 0 0", go, inc);
        end
        press(4'h7);
        checks++;
        if (cor !== 1'b0 || inc !== 1'b0 || sv !== 1'b0) begin
            errors++;
            $display("FAIL done_submit: cor=%b inc=%b sv=%b required 0 0 0", cor, inc, sv);
        end
        pulse_start();
        checks++;
        if (lvl !== 4'd1 || lives !== 3'd2) begin
            errors++;
            $display("FAIL restart: level=%0d lives=%0d required 1 2", lvl, lives);
        end
        model_gen(1, 1'b0);
        check_show(1);
        press(4'h7);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1) begin
            errors++;
            $display("FAIL no_reseed: cor=%b rd=%b required 1 1", cor, rd);
        end
    endtask

    task automatic test_simultaneous();
        int w;
        sel = 1'b0;
        do_reset();
        pulse_start();
        model_gen(1, 1'b0);
        check_show(1);
        repeat (9) tick();
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL pre_expiry: acc=%b required 1", acc);
        end
        press(4'h3);
        checks++;
        if (cor !== 1'b1 || inc !== 1'b0 || rd !== 1'b1) begin
            errors++;
            $display("FAIL submit_vs_expiry: cor=%b inc=%b rd=%b required 1 0 1", cor, inc, rd);
        end
        w = 0;
        while (sv !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        press(4'h7);
        checks++;
        if (cor !== 1'b0 || inc !== 1'b0 || sv !== 1'b1 || sd !== 4'h7) begin
            errors++;
            $display("FAIL show_submit: cor=%b inc=%b sv=%b sd=%h required 0 0 1 7", cor, inc, sv, sd);
        end
        w = 0;
        while (acc !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        press(4'h7);
        checks++;
        if (cor !== 1'b1 || inc !== 1'b0) begin
            errors++;
            $display("FAIL idx_kept: cor=%b inc=%b required 1 0", cor, inc);
        end
        press(4'hF);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1) begin
            errors++;
            $display("FAIL idx_kept_last: cor=%b rd=%b required 1 1", cor, rd);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        sel = 1'b0;
        do_reset();
        pulse_start();
        model_gen(1, 1'b0);
        check_show(1);
        press(4'h3);
        seen = 0;
        while (sv !== 1'b1 && seen < 40) begin
            tick();
            seen++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sv !== 1'b0 || sd !== 4'h0 || lvl !== 4'd1 || lives !== 3'd2 || acc !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sv=%b sd=%h level=%0d lives=%0d acc=%b required 0 0 1 2 0",
                     sv, sd, lvl, lives, acc);
        end
        checks++;
        if ({cor, inc, rd, go, win} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_pulses: %b required 00000", {cor, inc, rd, go, win});
        end
        seen = 0;
        repeat (6) begin
            tick();
            if (sv === 1'b1 || acc === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_idle: active_cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_append();
        int w;
        sel = 1'b1;
        do_reset();
        pulse_start();
        model_gen(1, 1'b1);
        check_show(1);
        press(4'h3);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1 || lvl !== 4'd2) begin
            errors++;
            $display("FAIL app_l1: cor=%b rd=%b level=%0d required 1 1 2", cor, rd, lvl);
        end
        model_gen(2, 1'b1);
        w = 0;
        while (sv !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (sd !== 4'h3) begin
            errors++;
            $display("FAIL app_keep: sd=%h required 3", sd);
        end
        check_show(2);
        press(4'h0);
        checks++;
        if (inc !== 1'b1 || lives !== 3'd1) begin
            errors++;
            $display("FAIL app_miss: inc=%b lives=%0d required 1 1", inc, lives);
        end
        check_show(2);
        press(4'h3);
        press(4'h7);
        checks++;
        if (cor !== 1'b1 || rd !== 1'b1 || lvl !== 4'd3) begin
            errors++;
            $display("FAIL app_l2: cor=%b rd=%b level=%0d required 1 1 3", cor, rd, lvl);
        end
        sel = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; rst = 1'b1; start = 1'b0; submit = 1'b0; entry = 4'h0;
        test_reset();
        test_level1();
        test_win();
        test_mismatch();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_append();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_game_core.md
Name: seq_game_core

Overview:
Parametrised sequence-memory game engine that replaces the separate sequence-generator, sequence-verify and entry-timer blocks with one core.
- Generates a pseudo-random digit sequence per level and plays it digit-by-digit to the display path.
- Accepts player entries, checks them in order, and enforces a per-entry timeout.
- Supports a lives count and two sequence modes: regenerate each round, or append one digit per round.
- Sits between the button shapers/switches and the controller/score logic; all outputs are single-cycle pulses or registered levels.

Parameters:
DIGIT_W, 4, bits per sequence digit and per player entry
MAX_LEVEL, 8, final level; sequence length equals the current level (1..MAX_LEVEL)
DISP_CYCLES, 50_000_000, cycles each digit is shown
GAP_CYCLES, 12_500_000, blank cycles between shown digits
ENTRY_TIMEOUT, 250_000_000, cycles allowed per entry
LIVES, 3, mismatches tolerated per game (1..7)
APPEND_MODE, 0, 0 = full new sequence each round; 1 = keep the previous digits and append one
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a game
submit  in  1  one-cycle pulse from the button shaper; samples entry
entry  in  DIGIT_W  player switch value
show_digit  out  DIGIT_W  digit being shown; 0 when show_valid=0
show_valid  out  1  high while a digit is being displayed
level  out  4  current level, 1..MAX_LEVEL
lives_left  out  3  remaining lives
accepting  out  1  high in ENTER state
correct  out  1  pulse, entry matched
incorrect  out  1  pulse, mismatch or timeout
round_done  out  1  pulse, whole sequence entered correctly
game_over  out  1  pulse, lives exhausted
game_win  out  1  pulse, MAX_LEVEL completed

Behaviour:
- Reset values: state IDLE, LFSR=SEED, level=1, lives_left=LIVES, show_digit=0, all pulses and show_valid/accepting = 0, sequence storage cleared.
- States: IDLE, GEN, SHOW_ON, SHOW_GAP, ENTER, DONE.
- IDLE:
  - start -> GEN with level=1, lives_left=LIVES.
  - submit is ignored.
- GEN:
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11; it steps once per generated digit.
  - Each digit is the LFSR's low DIGIT_W bits after the step.
  - APPEND_MODE=0: regenerate positions 0..level-1, one per cycle (level cycles).
  - APPEND_MODE=1: write only position level-1 (1 cycle).
  - Then go to SHOW_ON with idx=0.
- SHOW_ON:
  - show_valid=1 and show_digit=seq[idx] for exactly DISP_CYCLES cycles.
  - Then SHOW_GAP for GAP_CYCLES cycles, with show_valid=0.
  - After the gap: next idx, or ENTER with idx=0 after the last digit.
- ENTER:
  - accepting=1. The timeout counter loads ENTRY_TIMEOUT on entry to ENTER and after each accepted submit.
  - submit with entry==seq[idx]: correct pulses the next cycle and idx increments.
  - If that was the last digit, round_done pulses alongside correct.
    - If level==MAX_LEVEL: game_win pulses and the state goes to DONE.
    - Otherwise level increments and the state goes to GEN.
  - Mismatch, or the counter reaching 0: incorrect pulses the next cycle and lives_left decrements.
    - If lives_left becomes 0: game_over pulses and the state goes to DONE.
    - Otherwise replay the same sequence: SHOW_ON, idx=0, no regeneration.
  - submit and timeout expiry in the same cycle: submit wins.
- Outside ENTER: submit is ignored and has no side effects.
- start is ignored except in IDLE and DONE. In DONE it restarts exactly as from IDLE; the LFSR is not reseeded.
- Reset mid-operation returns every register to its reset value on the next edge; no pulse is emitted.
- Output latency: all outputs are registered, so pulses are one cycle wide and appear one cycle after the causing event.
- Counter widths: each counter is $clog2 of its parameter plus 1; no wrap occurs because counters reload before reaching terminal.

Decomposition:
- Package seq_game_pkg holds:
  - state enum (6 states)
  - LFSR tap mask constant
  - helper function for counter width
- One sub-module, seq_lfsr: 16-bit LFSR with SEED parameter, step enable and synchronous reset.
- Sequence storage is a MAX_LEVEL x DIGIT_W register array inside the core.

Test Plan:
Bench parameters for all tests: DISP_CYCLES=3, GAP_CYCLES=1, ENTRY_TIMEOUT=10, LIVES=2, MAX_LEVEL=3, SEED=16'hACE1.
- Reset and level-1 play: rst, then start -> after 1 GEN cycle, show_valid high 3 cycles with show_digit = the reference LFSR's first value[3:0], then 1 gap cycle, then accepting=1, level=1, lives_left=2.
- Correct play to win: enter each shown digit at every level -> correct pulse per entry; round_done at levels 1 and 2 with level going 1->2->3; after the third round, game_win for 1 cycle, accepting=0.
- Mismatch with replay: at level 2, wrong entry on idx 0 -> incorrect pulse, lives_left=1, same two digits re-shown. With APPEND_MODE=1, digit 0 equals the level-1 digit.
- Timeout and game over: no submit for 10 cycles, twice -> two incorrect pulses; game_over on the second, lives_left=0; a following start restarts at level=1, lives_left=2.
- Simultaneous events: correct submit on the cycle the counter hits 0 -> correct only, no incorrect. submit during SHOW_ON -> no pulse, idx unchanged.
- Reset mid-show: assert rst during SHOW_ON -> next cycle show_valid=0, level=1, state IDLE, no pulses.
